// File: rtl/for_chunk_copy.sv
// Multi-cycle word copier: captures a word on start, then writes it to out
// CHUNK bits per cycle, either straight or bit-reversed.
module for_chunk_copy #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8,
  localparam int N  = WIDTH / CHUNK,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    idx,
  output logic [WIDTH-1:0] out
);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("for_chunk_copy: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  state_e           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             md_q, md_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] rev_s;
  logic [WIDTH-1:0] src_s;
  logic [WIDTH-1:0] mask_s;
  int               shift_s;

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign rev_s[g] = snap_q[WIDTH-1-g];
  end

  assign src_s = md_q ? rev_s : snap_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    md_d    = md_q;
    out_d   = out_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_s = int'(idx_q) * CHUNK;
    mask_s  = CHUNK_MASK << shift_s;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = in;
          md_d    = mode;
          out_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_COPY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COPY: begin
        // Only the chunk addressed by idx is replaced; the rest of out holds.
        out_d = (out_q & ~mask_s) | (src_s & mask_s);
        if (idx_q == CW'(N - 1)) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      md_q    <= 1'b0;
      out_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      md_q    <= md_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign idx  = idx_q;
  assign out  = out_q;

endmodule

// File: tb/tb_for_chunk_copy.sv
// Directed bench for for_chunk_copy: default 128/8, N=1 (8/8) and 12/3 instances.
module tb_for_chunk_copy;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_start, a_mode, a_busy, a_done;
  logic [127:0] a_in, a_out;
  logic [3:0]   a_idx;

  logic         b_start, b_mode, b_busy, b_done;
  logic [7:0]   b_in, b_out;
  logic [0:0]   b_idx;

  logic         c_start, c_mode, c_busy, c_done;
  logic [11:0]  c_in, c_out;
  logic [1:0]   c_idx;

  for_chunk_copy u_dut (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .in(a_in),
    .busy(a_busy), .done(a_done), .idx(a_idx), .out(a_out)
  );

  for_chunk_copy #(.WIDTH(8), .CHUNK(8)) u_n1 (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .in(b_in),
    .busy(b_busy), .done(b_done), .idx(b_idx), .out(b_out)
  );

  for_chunk_copy #(.WIDTH(12), .CHUNK(3)) u_w12 (
    .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .in(c_in),
    .busy(c_busy), .done(c_done), .idx(c_idx), .out(c_out)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rev128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = v[127-i];
    return r;
  endfunction

  function automatic logic [127:0] wgen(input int c);
    return {32'hC0DE0000 | 32'(c), ~32'(c), 32'h13579BDF ^ (32'(c) * 32'd7), 32'(c) * 32'h01010101};
  endfunction

  localparam logic [127:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] K2 = 128'hFEED_FACE_CAFE_BEEF_0BAD_F00D_1234_5678;
  localparam logic [127:0] K3 = 128'h8000_0000_0000_0001_00F0_0000_0000_0003;

  initial begin
    logic [11:0] prog [0:3];
    int busy_cnt;
    prog[0] = 12'h000; prog[1] = 12'h004; prog[2] = 12'h03C; prog[3] = 12'h0BC;

    rst = 1'b1;
    a_start = 1'b0; a_mode = 1'b0; a_in = '0;
    b_start = 1'b0; b_mode = 1'b0; b_in = '0;
    c_start = 1'b0; c_mode = 1'b0; c_in = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset_out", a_out, 128'd0);
    chk("reset_busy", 128'(a_busy), 128'd0);
    chk("reset_done", 128'(a_done), 128'd0);
    chk("reset_idx", 128'(a_idx), 128'd0);
    chk("reset_n1_out", 128'(b_out), 128'd0);
    chk("reset_w12_out", 128'(c_out), 128'd0);

    // Straight copy of K1
    a_in = K1; a_mode = 1'b0; a_start = 1'b1;
    tick;
    a_start = 1'b0; a_in = '0;
    chk("t1_capture_out", a_out, 128'd0);
    chk("t1_capture_busy", 128'(a_busy), 128'd1);
    tick;
    chk("t1_chunk0_out", a_out, 128'h10);
    chk("t1_chunk0_idx", 128'(a_idx), 128'd1);
    for (int j = 2; j <= 15; j++) tick;
    chk("t1_e15_out", a_out, 128'h0023_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t1_e15_done", 128'(a_done), 128'd0);
    tick;
    chk("t1_done", 128'(a_done), 128'd1);
    chk("t1_done_out", a_out, K1);
    chk("t1_done_idx", 128'(a_idx), 128'd0);
    tick;
    chk("t1_idle_busy", 128'(a_busy), 128'd0);
    chk("t1_idle_done", 128'(a_done), 128'd0);
    chk("t1_hold_out", a_out, K1);

    // Reversed copy of 1
    a_in = 128'd1; a_mode = 1'b1; a_start = 1'b1;
    tick;
    a_start = 1'b0; a_in = '1; a_mode = 1'b0;
    for (int j = 1; j <= 15; j++) tick;
    chk("t2_e15_out", a_out, 128'd0);
    tick;
    chk("t2_done", 128'(a_done), 128'd1);
    chk("t2_done_out", a_out, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    tick;

    // start held high, in and mode changing every cycle
    busy_cnt = 0;
    a_start = 1'b1; a_in = wgen(0); a_mode = 1'b0;
    for (int j = 0; j <= 17; j++) begin
      tick;
      if (a_busy) busy_cnt++;
      if (j == 16) begin
        chk("t3_first_done", 128'(a_done), 128'd1);
        chk("t3_first_out", a_out, wgen(0));
      end
      a_in = wgen(j + 1);
      a_mode = (((j + 1) & 2) != 0);
    end
    chk("t3_busy_cycles", 128'(busy_cnt), 128'd17);
    chk("t3_idle_gap", 128'(a_busy), 128'd0);
    tick;
    a_start = 1'b0;
    chk("t3_second_busy", 128'(a_busy), 128'd1);
    chk("t3_second_out0", a_out, 128'd0);
    for (int j = 0; j < 16; j++) tick;
    chk("t3_second_done", 128'(a_done), 128'd1);
    chk("t3_second_out", a_out, rev128(wgen(18)));
    tick;

    // Reset in the middle of a copy
    a_in = K2; a_mode = 1'b0; a_start = 1'b1;
    tick;
    a_start = 1'b0;
    for (int j = 1; j <= 4; j++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t4_rst_out", a_out, 128'd0);
    chk("t4_rst_busy", 128'(a_busy), 128'd0);
    chk("t4_rst_idx", 128'(a_idx), 128'd0);
    chk("t4_rst_done", 128'(a_done), 128'd0);
    a_in = K3; a_mode = 1'b1; a_start = 1'b1;
    tick;
    a_start = 1'b0;
    for (int j = 0; j < 16; j++) tick;
    chk("t4_after_done", 128'(a_done), 128'd1);
    chk("t4_after_out", a_out, rev128(K3));
    tick;

    // N=1 reversed copy
    b_in = 8'hC1; b_mode = 1'b1; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("t5_capture_busy", 128'(b_busy), 128'd1);
    chk("t5_capture_out", 128'(b_out), 128'd0);
    tick;
    chk("t5_out", 128'(b_out), 128'h83);
    chk("t5_done", 128'(b_done), 128'd1);
    chk("t5_busy_done", 128'(b_busy), 128'd1);
    chk("t5_idx", 128'(b_idx), 128'd0);
    tick;
    chk("t5_idle_busy", 128'(b_busy), 128'd0);
    chk("t5_idle_done", 128'(b_done), 128'd0);
    chk("t5_hold_out", 128'(b_out), 128'h83);

    // 12/3 straight copy progression
    c_in = 12'hABC; c_mode = 1'b0; c_start = 1'b1;
    tick;
    c_start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t6_idx_%0d", j), 128'(c_idx), 128'(j));
      chk($sformatf("t6_out_%0d", j), 128'(c_out), 128'(prog[j]));
      tick;
    end
    chk("t6_final_out", 128'(c_out), 128'hABC);
    chk("t6_done", 128'(c_done), 128'd1);
    chk("t6_final_idx", 128'(c_idx), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
